// File: rtl/exception_flush_ctrl_pkg.sv
// Shared types and constants for the exception/ERET flush sequencer.
package exception_flush_ctrl_pkg;

  // Sequencer states, 2-bit encoding.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DRAIN    = 2'd1,
    S_FLUSH    = 2'd2,
    S_REDIRECT = 2'd3
  } state_e;

  // Kind of accepted request.
  typedef enum logic {
    KIND_EXC  = 1'b0,
    KIND_ERET = 1'b1
  } kind_e;

  // Offsets added to the exception vector base.
  localparam logic [11:0] REFILL_OFFSET  = 12'h000;
  localparam logic [11:0] GENERAL_OFFSET = 12'h180;

endpackage : exception_flush_ctrl_pkg

// File: rtl/exc_vector_calc.sv
// Combinational redirect-target selection for exceptions and ERET.
module exc_vector_calc
  import exception_flush_ctrl_pkg::*;
#(
  parameter logic [31:0] VEC_BASE = 32'hBFC0_0200
) (
  input  kind_e       kind_i,
  input  logic        tlb_refill_i,
  input  logic        status_exl_i,
  input  logic [31:0] epc_i,
  output logic [31:0] target_o
);

  logic [11:0] offset;

  // A TLB refill only uses the dedicated refill vector when not already at EXL.
  always_comb begin
    offset = GENERAL_OFFSET;
    if (tlb_refill_i && !status_exl_i) begin
      offset = REFILL_OFFSET;
    end
    if (kind_i == KIND_ERET) begin
      target_o = epc_i;
    end else begin
      target_o = VEC_BASE + {20'h0_0000, offset};
    end
  end

endmodule : exc_vector_calc

// File: rtl/exception_flush_ctrl.sv
// Sequencer turning an exception/ERET decision into drain, commit, flush and
// redirect steps for the pipeline.
module exception_flush_ctrl
  import exception_flush_ctrl_pkg::*;
#(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] VEC_BASE     = 32'hBFC0_0200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic        tlb_refill,
  input  logic        status_exl,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic        icache_busy,
  input  logic        dcache_busy,
  input  logic        redirect_ready,
  output logic        stall_all,
  output logic        flush_all,
  output logic        cp0_commit,
  output logic        eret_commit,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] target_q, target_d;
  logic        first_q, first_d;

  kind_e       accept_kind;
  logic [31:0] calc_target;

  // ExcCode travels straight to CP0; this block never stores or decodes it.
  logic        unused_exc_code;
  assign unused_exc_code = ^exc_code;

  // When both requests arrive together the exception takes priority.
  assign accept_kind = exc_req ? KIND_EXC : KIND_ERET;

  exc_vector_calc #(
    .VEC_BASE (VEC_BASE)
  ) u_vector_calc (
    .kind_i       (accept_kind),
    .tlb_refill_i (tlb_refill),
    .status_exl_i (status_exl),
    .epc_i        (epc),
    .target_o     (calc_target)
  );

  // State, counter, latched request and first-cycle marker registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      kind_q   <= KIND_EXC;
      cnt_q    <= 4'd0;
      target_q <= 32'h0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      first_q  <= first_d;
    end
  end

  // Next-state logic: accept in IDLE, wait out caches, count the flush, handshake.
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    first_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (exc_req || eret_req) begin
          kind_d   = accept_kind;
          target_d = calc_target;
          first_d  = 1'b1;
          if (icache_busy || dcache_busy) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_FLUSH;
            cnt_d   = FLUSH_LOAD;
          end
        end
      end
      S_DRAIN: begin
        if (!icache_busy && !dcache_busy) begin
          state_d = S_FLUSH;
          cnt_d   = FLUSH_LOAD;
        end
      end
      S_FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = S_REDIRECT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_REDIRECT: begin
        if (redirect_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode registered state only, so no input reaches an output directly.
  always_comb begin
    busy           = (state_q != S_IDLE);
    stall_all      = (state_q == S_DRAIN) || (state_q == S_FLUSH);
    flush_all      = (state_q == S_FLUSH);
    redirect_valid = (state_q == S_REDIRECT);
    redirect_pc    = target_q;
    cp0_commit     = first_q && (kind_q == KIND_EXC);
    eret_commit    = first_q && (kind_q == KIND_ERET);
  end

endmodule : exception_flush_ctrl

// File: doc/exception_flush_ctrl.md
# exception_flush_ctrl

Multi-cycle sequencer that takes an exception or ERET decision from the writeback-stage exception logic and turns it into an ordered pipeline action. It drains outstanding I/D-cache transactions, commits CP0 state exactly once, flushes every stage for a fixed number of cycles, then hands a redirect PC to the fetch stage over a valid/ready handshake. It sits between the exception logic / CP0 and the hazard unit / PC register.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 2: number of cycles `flush_all` is held; legal range 1–15.
- `VEC_BASE`, default 32'hBFC0_0200: exception vector base (BEV=1).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `exc_req`  in  1  exception decided this cycle (level).
- `exc_code`  in  5  ExcCode of the request.
- `tlb_refill`  in  1  request is a TLB refill (TLBL/TLBS with no matching entry).
- `status_exl`  in  1  current Status.EXL.
- `eret_req`  in  1  ERET reached writeback.
- `epc`  in  32  current CP0 EPC.
- `icache_busy`  in  1  I-cache refill in flight.
- `dcache_busy`  in  1  D-cache refill or writeback in flight.
- `redirect_ready`  in  1  fetch accepts the redirect.
- `stall_all`  out  1  freeze all stages.
- `flush_all`  out  1  clear all stage registers.
- `cp0_commit`  out  1  one-cycle pulse; CP0 latches exception writes.
- `eret_commit`  out  1  one-cycle pulse; CP0 clears EXL.
- `redirect_valid`  out  1  redirect PC available.
- `redirect_pc`  out  32  target PC.
- `busy`  out  1  FSM not in IDLE.

## Operation
- States: IDLE, DRAIN, FLUSH, REDIRECT, encoded in 2 bits.
- IDLE: a request is accepted when `exc_req` or `eret_req` is high.
  - If both are high, the exception wins and ERET is dropped.
  - On acceptance, latch the kind (EXC/ERET) and compute the target.
    - ERET target: `epc`.
    - Exception target: `VEC_BASE` + offset.
    - Offset is 12'h000 if `tlb_refill` is 1 and `status_exl` is 0; otherwise 12'h180.
    - Target addition is 32-bit with no carry-out.
  - Next state is DRAIN if `icache_busy` or `dcache_busy` is high, else FLUSH.
- DRAIN: `stall_all` is 1. Stay until both busy inputs are low, then go to FLUSH. There is no timeout.
- FLUSH:
  - `flush_all` is 1 and `stall_all` is 1.
  - A 4-bit counter loads `FLUSH_CYCLES-1` on entry, decrements each cycle, and moves to REDIRECT at 0.
- REDIRECT:
  - `redirect_valid` is 1 and `redirect_pc` holds the latched target. `stall_all` is 0 and `flush_all` is 0.
  - Stay until `redirect_ready` is high, then go to IDLE.
- Commit:
  - `cp0_commit` (EXC) or `eret_commit` (ERET) is asserted for exactly one cycle: the first cycle after acceptance, whether that is DRAIN or FLUSH.
  - Never more than one commit per accepted request.
- New requests are ignored while `busy` is 1; no queuing.
- `exc_code` is not stored. It is used only for `tlb_refill` qualification by the source and is passed to CP0 unchanged.

## Timing
- Reset: state IDLE, counter 0, latched target 0.
  - All outputs are 0 on reset: `stall_all`, `flush_all`, `cp0_commit`, `eret_commit`, `redirect_valid`, `redirect_pc` (32'h0), `busy`.
  - Reset mid-operation aborts immediately. No commit or redirect is emitted afterwards.
- All outputs are registered or decoded from registered state only; there is no combinational input-to-output path.
- Minimum latency from an accepted request to `redirect_valid` is 1 + `FLUSH_CYCLES` cycles (no drain).
- DRAIN adds one cycle per busy cycle.
- `redirect_pc` is stable for the whole time `redirect_valid` is high.
- A request in the same cycle as the `redirect_ready` handshake is not accepted. It is seen next cycle in IDLE if still asserted.
- `busy` is high from the cycle after acceptance through the handshake cycle.

## Structure
- The shared package holds:
  - the state enum;
  - the kind enum (EXC/ERET);
  - the refill offset constant 12'h000 and the general offset constant 12'h180.
- Sub-module `exc_vector_calc`: purely combinational target selection from the kind, `tlb_refill`, `status_exl` and `epc`.
- The FSM and counter stay in the top module.

## Test plan
- Syscall, caches idle, `FLUSH_CYCLES`=2:
  - `exc_req`=1, `exc_code`=8 in cycle 0.
  - `cp0_commit` is high in cycle 1 only.
  - `flush_all` is high in cycles 1–2.
  - `redirect_valid` is high in cycle 3 with `redirect_pc`=BFC0_0380.
- TLB refill with `status_exl`=0: `redirect_pc`=BFC0_0200. With `status_exl`=1: `redirect_pc`=BFC0_0380.
- ERET with `epc`=8000_1234 while `dcache_busy` is high for 5 cycles:
  - `stall_all` is high for 5 DRAIN cycles.
  - `eret_commit` fires once, in the first DRAIN cycle.
  - `redirect_pc`=8000_1234.
- `exc_req` and `eret_req` high in the same cycle: only `cp0_commit` pulses and the target is the vector.
- `redirect_ready` held low for 4 cycles with a new `exc_req` raised meanwhile:
  - `redirect_pc` stays stable.
  - The second request produces no commit until IDLE is re-entered.
- `rst` asserted during FLUSH: next cycle all outputs are 0 and `busy` is 0, with no later commit or redirect.
